// File: rtl/sc_spi_target.sv
// SPI target engine: oversamples SCLK/CSB/MOSI on SPICLK, shifts MISO from a word-wise TX buffer
// and delivers received 32-bit words. Define SC_SPI_TGT_SYNC3_EN to force a three-stage synchronizer.
module sc_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        SPICLK,
  input  logic        SYSRSTB,
  input  logic [8:0]  DWIDTH,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic        ENABLE,
  input  logic [31:0] TXDATA,
  output logic [3:0]  TXDPT,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic [3:0]  RXDPT,
  output logic        RXABORT,
  output logic        OVERRUN,
  output logic        BUSY,
  input  logic        SCLK,
  input  logic        CSB,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE
);

`ifdef SC_SPI_TGT_SYNC3_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = SYNC_STAGES;
`endif

  typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;

  state_t state, state_next;

  logic [STAGES-1:0] sclk_q, csb_q, mosi_q;
  logic              sclk_d, csb_d;
  logic              sclk_s, csb_s, mosi_s;
  logic              sample_edge, shift_edge, csb_fall, active;
  logic [8:0]        bc;
  logic [31:0]       rx_sh, rx_ins, tx_word;
  logic [2:0]        bit_in_byte;
  logic [4:0]        bpos;
  logic              tx_bit, frame_end, word_end;
  logic [3:0]        abort_dpt;

  function automatic logic [31:0] order(input logic [31:0] w, input logic border);
    return border ? w : {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // CSB synchronizer resets high so the bus looks deselected coming out of reset.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      sclk_q <= '0;
      csb_q  <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      csb_d  <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[STAGES-2:0], SCLK};
      csb_q  <= {csb_q[STAGES-2:0], CSB};
      mosi_q <= {mosi_q[STAGES-2:0], MOSI};
      sclk_d <= sclk_q[STAGES-1];
      csb_d  <= csb_q[STAGES-1];
    end
  end

  assign sclk_s      = sclk_q[STAGES-1];
  assign csb_s       = csb_q[STAGES-1];
  assign mosi_s      = mosi_q[STAGES-1];
  assign sample_edge = (CPOL == CPHA) ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
  assign shift_edge  = (CPOL == CPHA) ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
  assign csb_fall    = csb_d & ~csb_s;
  assign active      = ~csb_s & ENABLE;
  assign BUSY        = active;
  assign TXDPT       = bc[8:5];

  // A short final byte is LSB-aligned, so its bits count down from DWIDTH[2:0].
  assign bit_in_byte = (bc[8:3] == DWIDTH[8:3]) ? (DWIDTH[2:0] - bc[2:0]) : (3'd7 - bc[2:0]);
  assign bpos        = {bc[4:3], bit_in_byte};
  assign tx_word     = order(TXDATA, BORDER);
  assign tx_bit      = tx_word[bpos];
  assign frame_end   = (bc == DWIDTH);
  assign word_end    = (bpos == 5'd24) | frame_end;
  assign abort_dpt   = (bc[4:0] == 5'd0 && bc[8:5] != 4'd0) ? bc[8:5] - 4'd1 : bc[8:5];

  always_comb begin
    rx_ins       = rx_sh;
    rx_ins[bpos] = mosi_s;
  end

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    MISO_OE    = 1'b0;
    case (state)
      IDLE: if (csb_fall && active) state_next = DATA;
      DATA: begin
        MISO_OE = ENABLE;
        if (!active)                        state_next = IDLE;
        else if (sample_edge && frame_end)  state_next = DONE;
      end
      DONE: begin
        MISO_OE = ENABLE;
        if (!active) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Leaving DATA early still hands over whatever was collected, flagged as an abort.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      bc      <= '0;
      rx_sh   <= '0;
      MISO    <= 1'b0;
      RXDATA  <= '0;
      RXDPT   <= '0;
      RXVALID <= 1'b0;
      RXABORT <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      RXVALID <= 1'b0;
      RXABORT <= 1'b0;
      OVERRUN <= 1'b0;
      case (state)
        IDLE: begin
          bc    <= '0;
          rx_sh <= '0;
          MISO  <= (csb_fall && active) ? tx_bit : 1'b0;
        end
        DATA: begin
          if (!active) begin
            bc      <= '0;
            rx_sh   <= '0;
            MISO    <= 1'b0;
            RXVALID <= 1'b1;
            RXABORT <= 1'b1;
            RXDATA  <= order(rx_sh, BORDER);
            RXDPT   <= abort_dpt;
          end else if (sample_edge) begin
            if (word_end) begin
              RXVALID <= 1'b1;
              RXDATA  <= order(rx_ins, BORDER);
              RXDPT   <= bc[8:5];
              rx_sh   <= '0;
            end else begin
              rx_sh <= rx_ins;
            end
            if (frame_end) MISO <= 1'b0;
            else           bc   <= bc + 9'd1;
          end else if (shift_edge) begin
            MISO <= tx_bit;
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (!active) begin
            bc    <= '0;
            rx_sh <= '0;
          end else if (sample_edge) begin
            OVERRUN <= 1'b1;
          end
        end
        default: begin
          bc    <= '0;
          rx_sh <= '0;
          MISO  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sc_spi_target.md
Name: sc_spi_target

Overview:
SPI target (slave-side) protocol engine. It sits in the same SPI engine as the master controller, on the far side of the bus.
- Oversamples an external SPI bus (SCLK/CSB/MOSI) on the system SPICLK.
- Shifts out MISO from a word-wise TX buffer.
- Delivers received 32-bit words with a buffer pointer and a valid strobe.
- Framing parameters (DWIDTH, CPOL, CPHA, BORDER) match the master controller, so master and target interoperate bit-for-bit.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for SCLK/CSB/MOSI (overridden to 3 by the optional feature).

Ports:
- SPICLK  in  1  system clock; must be ≥ 8× SCLK frequency.
- SYSRSTB  in  1  reset; asynchronous, active-low.
- DWIDTH  in  9  frame length minus 1, in bits (frame = DWIDTH+1 bits, max 512).
- CPOL  in  1  clock polarity.
- CPHA  in  1  clock phase.
- BORDER  in  1  byte order; 1: TXDATA[7:0] is byte 0, 0: TXDATA[31:24] is byte 0.
- ENABLE  in  1  target enable; 0 holds the FSM in IDLE and forces MISO_OE=0.
- TXDATA  in  32  TX word addressed by TXDPT.
- TXDPT  out  4  TX word pointer, equal to bitcount[8:5].
- RXDATA  out  32  received word (byte-ordered per BORDER).
- RXVALID  out  1  1-cycle strobe: RXDATA/RXDPT valid.
- RXDPT  out  4  word index of RXDATA.
- RXABORT  out  1  1-cycle strobe: CSB rose before DWIDTH+1 bits were received.
- OVERRUN  out  1  1-cycle strobe: a sample edge arrived after the frame completed.
- BUSY  out  1  high while CSB (synchronized) is asserted.
- SCLK  in  1  SPI clock from the master.
- CSB  in  1  chip select, active-low.
- MOSI  in  1  master out, target in.
- MISO  out  1  target out, master in.
- MISO_OE  out  1  MISO output enable (for an external tristate buffer).

Behaviour:
- Reset values: all outputs 0 except RXDATA=0 and RXDPT=0; FSM in IDLE; bit counter bc=0.
- Synchronization: SCLK, CSB and MOSI each pass through SYNC_STAGES flops. Edges are detected from the last two stages.
- Edge mapping:
  - Sample edge = SCLK rising when CPOL==CPHA, otherwise SCLK falling.
  - Shift edge = the opposite edge.
- FSM states:
  - IDLE: CSB_s high or ENABLE=0. bc=0, MISO=0, MISO_OE=0. On a CSB_s falling edge with ENABLE=1 → DATA, and MISO is driven with bit 0 of the frame on the next cycle. This is required for CPHA=0.
  - DATA: on a sample edge, store MOSI_s at bit position bpos(bc).
    - If bc==DWIDTH → DONE.
    - Otherwise bc+1; the following shift edge updates MISO to bit bpos(bc).
    - CPHA=1: the first shift edge only presents bit 0; no bc advance before the first sample.
  - DONE: MISO=0. Each further sample edge pulses OVERRUN; no data is stored. CSB_s high → IDLE.
  - Any state: CSB_s high → IDLE within 1 cycle.
    - If the state was DATA, the partial word is delivered with RXVALID and RXABORT pulsed in the same cycle.
    - ENABLE falling mid-frame has the same effect as CSB_s high.
- Bit position:
  - Normal byte: bpos = bc[4:3]*8 + (7 − bc[2:0]), MSB first within each byte.
  - Last byte (bc[8:3]==DWIDTH[8:3]): bpos = bc[4:3]*8 + (DWIDTH[2:0] − bc[2:0]), so a partial last byte is LSB-aligned.
- TX: bit = swapped(TXDATA)[bpos]. swapped = TXDATA when BORDER=1, byte-reversed when BORDER=0. TXDATA must be stable while TXDPT is constant.
- RX: the shift word clears at frame start and after each delivery.
  - Delivery occurs one cycle after the sample with bpos==24 (end of word) or bc==DWIDTH (end of frame).
  - RXDATA = swapped shift word; RXDPT = bc[8:5] of the last stored bit; RXVALID=1 for 1 cycle.
- Latency: MOSI pin → stored in ≤ SYNC_STAGES+2 SPICLK cycles. Shift edge at pin → MISO update in ≤ SYNC_STAGES+2 cycles.
- BUSY = CSB_s low and ENABLE=1.
- Glitch handling: a CSB_s pulse shorter than 1 SPICLK is filtered by the synchronizer only. No further filtering is applied.

Optional Feature:
- Macro SC_SPI_TGT_SYNC3_EN.
- Defined: SYNC_STAGES is forced to 3 regardless of the parameter, and all latencies increase by 1 cycle.
- Undefined: SYNC_STAGES parameter value is used (default 2).

Test Plan:
1. Mode 0, DWIDTH=31, BORDER=1, TXDATA=0xA55A_C33C, master sends 0x1234_5678 → MISO stream = bytes 3C,C3,5A,A5 (MSB first); one RXVALID, RXDPT=0, RXDATA=0x1234_5678.
2. Modes 1/2/3, same data → identical RXDATA and MISO byte stream; for CPHA=0, MISO bit 0 is valid before the first SCLK edge.
3. DWIDTH=63, BORDER=0 → two RXVALID strobes with RXDPT=0 then 1; TXDPT steps 0→1 after bit 32.
4. DWIDTH=11 (12 bits), master sends 0xAB then 0xC (4 bits) → RXDATA byte0=0xAB, byte1=0x0C; RXVALID once.
5. CSB raised after 10 of 32 bits → RXVALID and RXABORT pulse together; next frame starts with bc=0.
6. 34 SCLK pulses with DWIDTH=31 → two OVERRUN pulses, MISO=0 after the frame; both with and without SC_SPI_TGT_SYNC3_EN.
